// File: rtl/alu_simple.sv
// alu_simple: 32-bit single-cycle ALU with a registered result.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset; clears Out on the edge it is sampled low
//   In1      operand A, also the shift/rotate source
//   In2      operand B
//   opcode   operation select (ADD, SUB, MUL, AND, OR, XOR, NOR, SLT, SLTU, SHIFT, PASS B)
//   SR_Cont  shift/rotate mode, only meaningful when opcode is SHIFT
//   SR_Bit   shift/rotate amount 0..31, only meaningful when opcode is SHIFT
//   Out      result of the inputs sampled at the previous rising edge
//
// No flags are produced; carries and overflows simply wrap modulo 2^32.

module alu_simple (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic [3:0]  opcode,
  input  logic [2:0]  SR_Cont,
  input  logic [4:0]  SR_Bit,
  output logic [31:0] Out
);

  typedef enum logic [3:0] {
    OpAdd   = 4'b0000,
    OpSub   = 4'b0001,
    OpMul   = 4'b0010,
    OpAnd   = 4'b0011,
    OpOr    = 4'b0100,
    OpXor   = 4'b0101,
    OpNor   = 4'b0110,
    OpSlt   = 4'b0111,
    OpSltu  = 4'b1000,
    OpShift = 4'b1001,
    OpPassB = 4'b1010
  } op_e;

  logic [5:0]  rot_amt;
  logic [31:0] shift_res;
  logic [31:0] alu_res;

  // Complementary amount for rotates; a shift by 32 yields zero, so SR_Bit=0
  // degenerates cleanly to the unrotated operand.
  assign rot_amt = 6'd32 - {1'b0, SR_Bit};

  always_comb begin
    shift_res = In1;
    case (SR_Cont)
      3'b001:  shift_res = In1 << SR_Bit;
      3'b010:  shift_res = In1 >> SR_Bit;
      3'b011:  shift_res = $unsigned($signed(In1) >>> SR_Bit);
      3'b100:  shift_res = (In1 << SR_Bit) | (In1 >> rot_amt);
      3'b101:  shift_res = (In1 >> SR_Bit) | (In1 << rot_amt);
      default: shift_res = In1;
    endcase
  end

  always_comb begin
    alu_res = 32'h0;
    case (opcode)
      OpAdd:   alu_res = In1 + In2;
      OpSub:   alu_res = In1 - In2;
      // Low half of the product is identical for signed and unsigned operands.
      OpMul:   alu_res = In1 * In2;
      OpAnd:   alu_res = In1 & In2;
      OpOr:    alu_res = In1 | In2;
      OpXor:   alu_res = In1 ^ In2;
      OpNor:   alu_res = ~(In1 | In2);
      OpSlt:   alu_res = {31'h0, $signed(In1) < $signed(In2)};
      OpSltu:  alu_res = {31'h0, In1 < In2};
      OpShift: alu_res = shift_res;
      OpPassB: alu_res = In2;
      default: alu_res = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Out <= 32'h0;
    end else begin
      Out <= alu_res;
    end
  end

endmodule

// File: tb/tb_alu_simple.sv
// tb_alu_simple: directed self-checking bench for alu_simple.
// Inputs change shortly after each rising edge; Out is sampled 1 time unit
// after the following rising edge and compared with hand-computed values.

module tb_alu_simple;

  logic        clk;
  logic        rst_n;
  logic [31:0] In1;
  logic [31:0] In2;
  logic [3:0]  opcode;
  logic [2:0]  SR_Cont;
  logic [4:0]  SR_Bit;
  logic [31:0] Out;

  int checks;
  int errors;

  alu_simple dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .In1     (In1),
    .In2     (In2),
    .opcode  (opcode),
    .SR_Cont (SR_Cont),
    .SR_Bit  (SR_Bit),
    .Out     (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] cont, input logic [4:0] amt);
    opcode  = op;
    In1     = a;
    In2     = b;
    SR_Cont = cont;
    SR_Bit  = amt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (Out === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, Out, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(4'b0000, 32'd5, 32'd7, 3'b000, 5'd0);

    // Reset overrides the pending ADD, and holds across consecutive edges.
    tick();
    check("reset_add", 32'h0);
    tick();
    check("reset_hold", 32'h0);
    rst_n = 1'b1;
    tick();
    check("release_add", 32'd12);

    // MUL with shift controls set: SR_Bit must not matter.
    drive(4'b0010, 32'd3479807, 32'd312578093, 3'b000, 5'd3);
    tick();
    check("mul", 32'd2378421459);
    drive(4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 5'd7);
    tick();
    check("mul_neg", 32'h00000001);

    // Wrap-around and compares.
    drive(4'b0000, 32'hFFFFFFFF, 32'd1, 3'b001, 5'd9);
    tick();
    check("add_wrap", 32'h0);
    drive(4'b0001, 32'h0, 32'd1, 3'b000, 5'd0);
    tick();
    check("sub_wrap", 32'hFFFFFFFF);
    drive(4'b0111, 32'hFFFFFFFF, 32'd1, 3'b000, 5'd0);
    tick();
    check("slt_neg", 32'd1);
    drive(4'b1000, 32'hFFFFFFFF, 32'd1, 3'b000, 5'd0);
    tick();
    check("sltu_big", 32'd0);

    // Shifts and rotates on 0x80000001.
    drive(4'b1001, 32'h80000001, 32'h0, 3'b001, 5'd1);
    tick();
    check("sll1", 32'h00000002);
    drive(4'b1001, 32'h80000001, 32'h0, 3'b011, 5'd4);
    tick();
    check("sra4", 32'hF8000000);
    drive(4'b1001, 32'h80000001, 32'h0, 3'b101, 5'd1);
    tick();
    check("ror1", 32'hC0000000);
    drive(4'b1001, 32'h80000001, 32'h0, 3'b100, 5'd0);
    tick();
    check("rol0", 32'h80000001);
    drive(4'b1001, 32'h80000001, 32'h0, 3'b010, 5'd0);
    tick();
    check("srl0", 32'h80000001);
    drive(4'b1001, 32'h80000001, 32'h0, 3'b011, 5'd0);
    tick();
    check("sra0", 32'h80000001);
    drive(4'b1001, 32'h80000001, 32'h0, 3'b000, 5'd7);
    tick();
    check("shift_mode0", 32'h80000001);

    // Logic ops and unused opcode.
    drive(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 5'd0);
    tick();
    check("and", 32'hF000F000);
    drive(4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 5'd0);
    tick();
    check("xor", 32'h0FF00FF0);
    drive(4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 5'd0);
    tick();
    check("nor", 32'h000F000F);
    drive(4'b1111, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 5'd0);
    tick();
    check("op1111", 32'h0);

    // Back-to-back stream: inputs change every cycle.
    drive(4'b0000, 32'd10, 32'd20, 3'b000, 5'd0);
    tick();
    check("lat_add", 32'd30);
    drive(4'b0001, 32'd5, 32'd9, 3'b000, 5'd0);
    tick();
    check("lat_sub", 32'hFFFFFFFC);
    drive(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 5'd0);
    tick();
    check("lat_or", 32'hFFF0FFF0);
    drive(4'b1010, 32'hAAAAAAAA, 32'h12345678, 3'b001, 5'd4);
    tick();
    check("lat_passb", 32'h12345678);
    drive(4'b1001, 32'h80000000, 32'h0, 3'b010, 5'd31);
    tick();
    check("lat_srl31", 32'h00000001);
    drive(4'b0111, 32'd3, 32'd3, 3'b000, 5'd0);
    tick();
    check("lat_slt_eq", 32'd0);
    drive(4'b1000, 32'd1, 32'hFFFFFFFF, 3'b000, 5'd0);
    tick();
    check("lat_sltu", 32'd1);
    drive(4'b1001, 32'hDEADBEEF, 32'h0, 3'b110, 5'd5);
    tick();
    check("lat_mode6", 32'hDEADBEEF);
    drive(4'b1001, 32'h80000001, 32'h0, 3'b100, 5'd4);
    tick();
    check("lat_rol4", 32'h00000018);
    drive(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 5'd0);
    tick();
    check("lat_op1011", 32'h0);

    // Mid-cycle input change must not reach Out before the edge.
    drive(4'b0000, 32'd100, 32'd1, 3'b000, 5'd0);
    tick();
    check("pre_hold", 32'd101);
    drive(4'b0101, 32'hFFFF0000, 32'h00FFFF00, 3'b000, 5'd0);
    @(negedge clk);
    check("mid_hold", 32'd101);
    tick();
    check("post_edge", 32'hFF00FF00);

    // Reset mid-stream discards the pending result.
    rst_n = 1'b0;
    drive(4'b0101, 32'h12345678, 32'h0, 3'b000, 5'd0);
    tick();
    check("mid_reset", 32'h0);
    rst_n = 1'b1;
    drive(4'b0000, 32'd1, 32'd1, 3'b000, 5'd0);
    tick();
    check("after_reset", 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
